// File: rtl/sample_ram_reader.sv
// Sweeps an address range of a synchronous sample RAM, streams each word out through a
// 2-entry FIFO with valid/ready, and counts samples above a temperature threshold.
module sample_ram_reader #(
    parameter int AW        = 3,
    parameter int DW        = 12,
    parameter int THRESH    = 3643,
    parameter int ALARM_CNT = 4
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_words,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_q,
    output logic          ram_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic [AW:0]   hot_count,
    output logic          alarm
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [DW-1:0] THRESH_V = DW'(THRESH);
    localparam logic [AW:0]   ALARM_V  = (AW+1)'(ALARM_CNT);

    state_t        state;
    state_t        state_next;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          inflight_last;
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [2:0]    eff_occ;
    logic          accept;
    logic          push;
    logic          pop;
    logic          issue;
    logic          issue_last;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign push      = inflight;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign busy      = (state == READ) || (state == DRAIN);
    assign alarm     = (hot_count >= ALARM_V);
    assign ram_rd    = issue;

    // A pop in this cycle frees its slot, which keeps one read per cycle under full throughput.
    always_comb begin
        eff_occ    = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
        issue      = (state == READ) && (eff_occ < 3'd2);
        issue_last = issue && (remaining == (AW+1)'(1));
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = READ;
            READ:       if (issue_last) state_next = DRAIN;
            DRAIN:      if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop)))
                            state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
            fifo_last     <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= '0;
            hot_count     <= '0;
        end else begin
            if (accept) begin
                ram_addr  <= base_addr;
                remaining <= (num_words == '0) ? (AW+1)'(1) : num_words;
            end else if (issue) begin
                ram_addr  <= ram_addr + AW'(1);
                remaining <= remaining - (AW+1)'(1);
            end
            inflight      <= issue;
            inflight_last <= issue_last;
            if (push) begin
                fifo_data[wr_ptr] <= ram_q;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
            // The hot check uses the sample at the moment it enters the FIFO.
            if (accept)
                hot_count <= '0;
            else if (push && (ram_q > THRESH_V) && (hot_count != '1))
                hot_count <= hot_count + (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_sample_ram_reader.sv
// Directed bench for sample_ram_reader with a synchronous RAM model and
// per-scenario tasks that compare against hand-computed schedules.
module tb_sample_ram_reader;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  base_addr;
    logic [3:0]  num_words;
    logic [2:0]  ram_addr;
    logic [11:0] ram_q = '0;
    logic        ram_rd;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic        busy;
    logic [3:0]  hot_count;
    logic        alarm;

    logic [11:0] mem [8];
    int checks = 0;
    int errors = 0;

    sample_ram_reader dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .ram_rd    (ram_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .hot_count (hot_count),
        .alarm     (alarm)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous single-port RAM: data appears the cycle after a read strobe.
    always @(posedge clk_in) begin
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) mem[i] = 12'((i + 1) * 100);
    endtask

    task automatic do_start(input logic [2:0] b, input logic [3:0] n);
        @(negedge clk_in);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        @(negedge clk_in);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0d want 0", out_valid); end
        checks++; if (out_data !== 12'd0) begin errors++; $display("[TB] FAIL reset_data: got %0d want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %0d want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d want 0", busy); end
        checks++; if (ram_rd !== 1'b0 || ram_addr !== 3'd0) begin errors++; $display("[TB] FAIL reset_ram: got rd=%0d addr=%0d want 0/0", ram_rd, ram_addr); end
        checks++; if (hot_count !== 4'd0 || alarm !== 1'b0) begin errors++; $display("[TB] FAIL reset_hot: got %0d/%0d want 0/0", hot_count, alarm); end
        rst_n = 1'b1;
        @(negedge clk_in);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%0d valid=%0d want 0/0", busy, out_valid); end
    endtask

    task automatic test_full_sweep();
        logic        exp_valid;
        logic [11:0] exp_data;
        out_ready = 1'b1;
        load_ramp();
        do_start(3'd0, 4'd8);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sweep_busy: got %0d want 1", busy); end
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk_in);
            exp_valid = (k >= 2) && (k <= 9);
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL sweep_valid k=%0d: got %0d want %0d", k, out_valid, exp_valid); end
            if (exp_valid) begin
                exp_data = 12'((k - 1) * 100);
                checks++; if (out_data !== exp_data) begin errors++; $display("[TB] FAIL sweep_data k=%0d: got %0d want %0d", k, out_data, exp_data); end
                checks++; if (out_last !== (k == 9)) begin errors++; $display("[TB] FAIL sweep_last k=%0d: got %0d want %0d", k, out_last, (k == 9)); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sweep_busy_end: got %0d want 0", busy); end
        checks++; if (hot_count !== 4'd0 || alarm !== 1'b0) begin errors++; $display("[TB] FAIL sweep_hot: got %0d/%0d want 0/0", hot_count, alarm); end
    endtask

    task automatic test_backpressure();
        int          idx = 0;
        logic        prev_stall = 1'b0;
        logic [11:0] prev_data = '0;
        out_ready = 1'b1;
        load_ramp();
        do_start(3'd0, 4'd8);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk_in);
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++; $display("[TB] FAIL stall_hold c=%0d: got valid=%0d data=%0d want 1/%0d", c, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                if (idx >= 8) begin
                    checks++; errors++;
                    $display("[TB] FAIL extra_transfer c=%0d: got data=%0d want no transfer", c, out_data);
                end else begin
                    checks++; if (out_data !== 12'((idx + 1) * 100)) begin errors++; $display("[TB] FAIL bp_data idx=%0d: got %0d want %0d", idx, out_data, (idx + 1) * 100); end
                    checks++; if (out_last !== (idx == 7)) begin errors++; $display("[TB] FAIL bp_last idx=%0d: got %0d want %0d", idx, out_last, (idx == 7)); end
                end
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        out_ready = 1'b1;
        checks++; if (idx !== 8) begin errors++; $display("[TB] FAIL bp_count: got %0d want 8", idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_busy_end: got %0d want 0", busy); end
    endtask

    task automatic test_hot();
        int   cum [8] = '{0, 1, 2, 3, 3, 4, 4, 4};
        int   exp_hot;
        logic exp_alarm;
        mem = '{12'd3643, 12'd3644, 12'd4095, 12'd3644, 12'd100, 12'd3700, 12'd0, 12'd3643};
        out_ready = 1'b1;
        do_start(3'd0, 4'd8);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk_in);
            exp_hot   = (k < 2) ? 0 : cum[(k - 2 > 7) ? 7 : k - 2];
            exp_alarm = (exp_hot >= 4);
            checks++; if (hot_count !== 4'(exp_hot)) begin errors++; $display("[TB] FAIL hot_count k=%0d: got %0d want %0d", k, hot_count, exp_hot); end
            checks++; if (alarm !== exp_alarm) begin errors++; $display("[TB] FAIL hot_alarm k=%0d: got %0d want %0d", k, alarm, exp_alarm); end
        end
        repeat (3) @(negedge clk_in);
        checks++; if (alarm !== 1'b1 || hot_count !== 4'd4) begin errors++; $display("[TB] FAIL alarm_sticky: got %0d/%0d want 1/4", alarm, hot_count); end
    endtask

    task automatic test_wrap();
        logic        exp_valid;
        logic [11:0] exp_data [4] = '{12'd700, 12'd800, 12'd100, 12'd200};
        load_ramp();
        out_ready = 1'b1;
        do_start(3'd6, 4'd4);
        checks++; if (hot_count !== 4'd0 || alarm !== 1'b0) begin errors++; $display("[TB] FAIL start_clears_hot: got %0d/%0d want 0/0", hot_count, alarm); end
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk_in);
            if (k <= 3) begin
                checks++;
                if (ram_rd !== 1'b1 || ram_addr !== 3'((6 + k) % 8)) begin
                    errors++; $display("[TB] FAIL wrap_addr k=%0d: got rd=%0d addr=%0d want 1/%0d", k, ram_rd, ram_addr, (6 + k) % 8);
                end
            end
            exp_valid = (k >= 2) && (k <= 5);
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL wrap_valid k=%0d: got %0d want %0d", k, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_data !== exp_data[k - 2]) begin errors++; $display("[TB] FAIL wrap_data k=%0d: got %0d want %0d", k, out_data, exp_data[k - 2]); end
                checks++; if (out_last !== (k == 5)) begin errors++; $display("[TB] FAIL wrap_last k=%0d: got %0d want %0d", k, out_last, (k == 5)); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_busy_end: got %0d want 0", busy); end
    endtask

    task automatic test_single_word();
        int rd_pulses = 0;
        out_ready = 1'b1;
        do_start(3'd3, 4'd0);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk_in);
            if (ram_rd) rd_pulses++;
            checks++; if (out_valid !== (k == 2)) begin errors++; $display("[TB] FAIL single_valid k=%0d: got %0d want %0d", k, out_valid, (k == 2)); end
            if (k == 2) begin
                checks++; if (out_data !== 12'd400 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL single_word: got %0d/%0d want 400/1", out_data, out_last); end
            end
        end
        checks++; if (rd_pulses !== 1) begin errors++; $display("[TB] FAIL single_reads: got %0d want 1", rd_pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %0d want 0", busy); end
    endtask

    task automatic test_start_ignored();
        logic exp_valid;
        out_ready = 1'b1;
        do_start(3'd0, 4'd8);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk_in);
            start     = (k == 3);
            base_addr = 3'd5;
            num_words = 4'd2;
            exp_valid = (k >= 2) && (k <= 9);
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL ign_valid k=%0d: got %0d want %0d", k, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_data !== 12'((k - 1) * 100)) begin errors++; $display("[TB] FAIL ign_data k=%0d: got %0d want %0d", k, out_data, (k - 1) * 100); end
                checks++; if (out_last !== (k == 9)) begin errors++; $display("[TB] FAIL ign_last k=%0d: got %0d want %0d", k, out_last, (k == 9)); end
            end
        end
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy_end: got %0d want 0", busy); end
    endtask

    task automatic test_reset_mid_sweep();
        logic exp_valid;
        mem = '{12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd500, 12'd600, 12'd700, 12'd800};
        out_ready = 1'b1;
        do_start(3'd0, 4'd8);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk_in);
            if (k >= 2 && k <= 4) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 12'd4000) begin errors++; $display("[TB] FAIL pre_reset_data k=%0d: got %0d/%0d want 1/4000", k, out_valid, out_data); end
            end
        end
        checks++; if (hot_count !== 4'd4 || alarm !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_hot: got %0d/%0d want 4/1", hot_count, alarm); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 12'd0 || out_last !== 1'b0 || busy !== 1'b0 ||
            ram_rd !== 1'b0 || ram_addr !== 3'd0 || hot_count !== 4'd0 || alarm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid=%0d data=%0d last=%0d busy=%0d rd=%0d addr=%0d hot=%0d alarm=%0d want all 0",
                     out_valid, out_data, out_last, busy, ram_rd, ram_addr, hot_count, alarm);
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            checks++; if (out_valid !== 1'b0 || ram_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_quiet c=%0d: got valid=%0d rd=%0d busy=%0d want 0/0/0", c, out_valid, ram_rd, busy); end
        end
        do_start(3'd4, 4'd2);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk_in);
            exp_valid = (k == 2) || (k == 3);
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL restart_valid k=%0d: got %0d want %0d", k, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_data !== 12'(300 + k * 100)) begin errors++; $display("[TB] FAIL restart_data k=%0d: got %0d want %0d", k, out_data, 300 + k * 100); end
                checks++; if (out_last !== (k == 3)) begin errors++; $display("[TB] FAIL restart_last k=%0d: got %0d want %0d", k, out_last, (k == 3)); end
            end
        end
        checks++; if (hot_count !== 4'd0 || alarm !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_end: got hot=%0d alarm=%0d busy=%0d want 0/0/0", hot_count, alarm, busy); end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        $display("[TB] sample_ram_reader bench starting");
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_hot();
        test_wrap();
        test_single_word();
        test_start_ignored();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
